stadd_multi: RTL and testbench
==============================

Name: stadd_multi

Overview:
- Parametrised store-address unit for the FPE array → data-memory path.
- Accepts store ops `{func, dest address}` from the controller and delays each by a programmable number of cycles so it lines up with the array's result wave.
- When an op arrives, it captures the array output, permutes it through a bus-writable map table (lane mask plus rotation) and issues per-bank data-memory write enables.
- Extends the previous fixed 12-lane, 16-stage unit with parametrised lanes and depth, and adds an optional redundant-write suppression mode with a skip counter.

Parameters:
- NLANE, 12, number of PE lanes / DMEM banks.
- DATA_W, 16, bits per lane.
- DEPTH, 16, delay-line stages; max delay = DEPTH-1.
- DLY_W, 4, width of i_delay; DEPTH ≤ 2^DLY_W.
- FUNC_W, 6, op function field = map-table index; table has 2^FUNC_W entries.
- ADDR_W, 16, DMEM destination address width.
- RW, 4, rotate field width; RW ≥ clog2(NLANE).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_op_valid  in  1  store op issue strobe, one op per cycle max
- i_op_func  in  FUNC_W  map-table index for the op
- i_op_addr  in  ADDR_W  DMEM destination address
- i_delay  in  DLY_W  alignment delay in cycles, quasi-static
- i_cmp_mode  in  1  1 = suppress writes identical to the previous write
- i_fpearray  in  DATA_W*NLANE  PE array output, lane 0 in LSBs
- o_todmem  out  DATA_W*NLANE  permuted write data
- o_addr  out  ADDR_W  write address
- o_dmemwe  out  NLANE  per-bank write enable
- o_working  out  1  registered OR of all in-flight valid bits
- o_skip_cnt  out  16  count of suppressed writes, saturating
- i_exwe  in  1  table write strobe
- i_exre  in  1  table read strobe
- i_exa  in  FUNC_W  table entry index
- i_exwd  in  NLANE+RW  table write data `{rot, mask}`
- o_exrd  out  NLANE+RW  table read data

Behaviour:
- Reset: all pipeline valid bits, o_dmemwe, o_working, o_skip_cnt, o_addr, o_todmem and o_exrd are 0. Table entries reset to 0, i.e. mask 0, so an unprogrammed entry never writes.
- Delay line: stage 0 registers `{i_op_valid, func, addr}` every cycle. Stage k registers stage k-1.
- Tap: the tap is stage i_delay. Stage i_delay+1 is loaded with 0, so entries beyond the tap die. If i_delay ≥ DEPTH, the tap is stage DEPTH-1.
- Capture: when the tap is valid, i_fpearray, func and addr are registered into the capture stage at the next edge. Capture valid is cleared otherwise.
- Latency: o_dmemwe asserts exactly i_delay+2 cycles after the i_op_valid cycle. Back-to-back ops produce back-to-back writes.
- Output is combinational from the capture stage and table:
  - o_dmemwe = mask & {NLANE{cap_valid & ~skip}}.
  - o_todmem lane j = captured lane (j+rot) mod NLANE. rot ≥ NLANE is taken modulo NLANE.
  - o_addr = captured addr; it holds its value when not valid.
- Table read/write:
  - Write on i_exwe at the clock edge.
  - Lookup in the same cycle sees the old entry.
  - o_exrd registered one cycle after i_exre and holds its value otherwise.
  - Simultaneous i_exwe and i_exre to the same index returns the old value.
- Suppression, when i_cmp_mode=1: skip = cap_valid & last_valid & (data, func, addr all equal last_*).
  - last_* registers update only on a non-skipped valid write.
  - last_valid clears on reset and whenever i_cmp_mode=0.
  - A skip increments o_skip_cnt, which saturates at 0xFFFF.
- o_working: registered OR of stage 0..DEPTH-1 valid bits plus capture valid. It deasserts one cycle after the last write cycle.
- Changing i_delay in flight: ops currently beyond the new tap are discarded with no write. This is legal but unsupported for data correctness.
- Reset mid-operation clears everything immediately. No write is issued after rst_n rises until a new op completes.

Test Plan:
- Table[3] = {rot 0, mask 0xFFF}, i_delay=5, op func 3 addr 0x40 at cycle 10 → o_dmemwe=0xFFF at cycle 17 only, o_addr=0x40, o_todmem equals i_fpearray sampled at cycle 16.
- Table[1] = {rot 2, mask 0x00F}, lanes hold values 0..11, i_delay=0 → o_dmemwe=0x00F, o_todmem lanes 0..3 = 2,3,4,5.
- Four back-to-back ops with i_delay=15 → four consecutive write cycles starting 17 cycles after the first op. o_working stays high from the cycle after the first op until one cycle after the last write.
- i_cmp_mode=1, three identical ops (same data/func/addr) → only the first writes, o_skip_cnt=2. Changing the data on a fourth op → it writes.
- Unprogrammed func 9 → no o_dmemwe. Simultaneous exwe/exre to index 5 → o_exrd returns the old value; the next read returns the new value.
- Assert rst_n=0 with 3 ops in flight → no writes afterwards, o_working=0 and o_skip_cnt=0.

Source files
------------

// File: rtl/stadd_multi.sv
// Store-address unit: delays store ops to meet the FPE array result wave, then
// permutes the captured array output through a lane-mask/rotate table into DMEM.
module stadd_multi #(
   parameter int unsigned NLANE  = 12,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DLY_W  = 4,
   parameter int unsigned FUNC_W = 6,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned RW     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_op_valid,
   input  logic [FUNC_W-1:0]         i_op_func,
   input  logic [ADDR_W-1:0]         i_op_addr,
   input  logic [DLY_W-1:0]          i_delay,
   input  logic                      i_cmp_mode,
   input  logic [DATA_W*NLANE-1:0]   i_fpearray,
   output logic [DATA_W*NLANE-1:0]   o_todmem,
   output logic [ADDR_W-1:0]         o_addr,
   output logic [NLANE-1:0]          o_dmemwe,
   output logic                      o_working,
   output logic [15:0]               o_skip_cnt,
   input  logic                      i_exwe,
   input  logic                      i_exre,
   input  logic [FUNC_W-1:0]         i_exa,
   input  logic [NLANE+RW-1:0]       i_exwd,
   output logic [NLANE+RW-1:0]       o_exrd
);

   localparam int unsigned TW   = NLANE + RW;
   localparam int unsigned NENT = 2 ** FUNC_W;

   logic              stg_v [DEPTH];
   logic [FUNC_W-1:0] stg_f [DEPTH];
   logic [ADDR_W-1:0] stg_a [DEPTH];
   logic              nxt_v [DEPTH];
   logic [FUNC_W-1:0] nxt_f [DEPTH];
   logic [ADDR_W-1:0] nxt_a [DEPTH];

   logic                    tap_v;
   logic [FUNC_W-1:0]       tap_f;
   logic [ADDR_W-1:0]       tap_a;
   logic                    busy_d;
   int unsigned             tap;

   logic                    cap_v;
   logic [DATA_W*NLANE-1:0] cap_data;
   logic [FUNC_W-1:0]       cap_f;
   logic [ADDR_W-1:0]       cap_a;

   logic                    last_v;
   logic [DATA_W*NLANE-1:0] last_data;
   logic [FUNC_W-1:0]       last_f;
   logic [ADDR_W-1:0]       last_a;

   logic [TW-1:0]           tbl [NENT];
   logic [TW-1:0]           ent;
   logic [NLANE-1:0]        mask;
   logic [RW-1:0]           rot;
   logic                    skip;
   logic                    working_q;
   logic [15:0]             skip_cnt_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [TW-1:0]           exrd_q;

   // Stage tap+1 is forced empty so ops never propagate past the active tap.
   always_comb begin
      tap   = (32'(i_delay) >= DEPTH) ? DEPTH - 1 : 32'(i_delay);
      tap_v = 1'b0;
      tap_f = '0;
      tap_a = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (k == tap) begin
            tap_v = stg_v[k];
            tap_f = stg_f[k];
            tap_a = stg_a[k];
         end
      end
      nxt_v[0] = i_op_valid;
      nxt_f[0] = i_op_func;
      nxt_a[0] = i_op_addr;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         if (k == tap + 1) begin
            nxt_v[k] = 1'b0;
            nxt_f[k] = '0;
            nxt_a[k] = '0;
         end else begin
            nxt_v[k] = stg_v[k-1];
            nxt_f[k] = stg_f[k-1];
            nxt_a[k] = stg_a[k-1];
         end
      end
      busy_d = tap_v;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         busy_d = busy_d | nxt_v[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            stg_v[k] <= 1'b0;
            stg_f[k] <= '0;
            stg_a[k] <= '0;
         end
         cap_v     <= 1'b0;
         cap_data  <= '0;
         cap_f     <= '0;
         cap_a     <= '0;
         working_q <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            stg_v[k] <= nxt_v[k];
            stg_f[k] <= nxt_f[k];
            stg_a[k] <= nxt_a[k];
         end
         cap_v     <= tap_v;
         working_q <= busy_d;
         if (tap_v) begin
            cap_data <= i_fpearray;
            cap_f    <= tap_f;
            cap_a    <= tap_a;
         end
      end
   end

   always_comb begin
      ent  = tbl[cap_f];
      mask = ent[NLANE-1:0];
      rot  = ent[NLANE +: RW];
      skip = i_cmp_mode & cap_v & last_v & (cap_data == last_data) &
             (cap_f == last_f) & (cap_a == last_a);
   end

   always_comb begin
      int unsigned rot_m;
      int unsigned idx;
      o_todmem = '0;
      rot_m    = 32'(rot) % NLANE;
      for (int unsigned j = 0; j < NLANE; j++) begin
         idx = j + rot_m;
         if (idx >= NLANE) idx = idx - NLANE;
         for (int unsigned s = 0; s < NLANE; s++) begin
            if (s == idx) o_todmem[j*DATA_W +: DATA_W] = cap_data[s*DATA_W +: DATA_W];
         end
      end
   end

   assign o_dmemwe   = mask & {NLANE{cap_v & ~skip}};
   assign addr_q     = cap_a;
   assign o_addr     = addr_q;
   assign o_working  = working_q;
   assign o_skip_cnt = skip_cnt_q;
   assign o_exrd     = exrd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_v     <= 1'b0;
         last_data  <= '0;
         last_f     <= '0;
         last_a     <= '0;
         skip_cnt_q <= '0;
      end else begin
         if (!i_cmp_mode) begin
            last_v <= 1'b0;
         end else if (cap_v && !skip) begin
            last_v    <= 1'b1;
            last_data <= cap_data;
            last_f    <= cap_f;
            last_a    <= cap_a;
         end
         if (skip && skip_cnt_q != '1) skip_cnt_q <= skip_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NENT; i++) tbl[i] <= '0;
         exrd_q <= '0;
      end else begin
         if (i_exwe) tbl[i_exa] <= i_exwd;
         if (i_exre) exrd_q <= tbl[i_exa];
      end
   end

endmodule

// File: tb/tb_stadd_multi.sv
// Directed bench for stadd_multi: latency, permutation, back-to-back ops,
// write suppression, table access and mid-flight reset.
module tb_stadd_multi;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_op_valid;
   logic [5:0]   i_op_func;
   logic [15:0]  i_op_addr;
   logic [3:0]   i_delay;
   logic         i_cmp_mode;
   logic [191:0] i_fpearray;
   logic [191:0] o_todmem;
   logic [15:0]  o_addr;
   logic [11:0]  o_dmemwe;
   logic         o_working;
   logic [15:0]  o_skip_cnt;
   logic         i_exwe;
   logic         i_exre;
   logic [5:0]   i_exa;
   logic [15:0]  i_exwd;
   logic [15:0]  o_exrd;

   int n_chk  = 0;
   int n_pass = 0;

   stadd_multi #(
      .NLANE(12), .DATA_W(16), .DEPTH(16), .DLY_W(4),
      .FUNC_W(6), .ADDR_W(16), .RW(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_op_valid(i_op_valid), .i_op_func(i_op_func), .i_op_addr(i_op_addr),
      .i_delay(i_delay), .i_cmp_mode(i_cmp_mode), .i_fpearray(i_fpearray),
      .o_todmem(o_todmem), .o_addr(o_addr), .o_dmemwe(o_dmemwe),
      .o_working(o_working), .o_skip_cnt(o_skip_cnt),
      .i_exwe(i_exwe), .i_exre(i_exre), .i_exa(i_exa), .i_exwd(i_exwd),
      .o_exrd(o_exrd)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [191:0] pat(input int n);
      logic [191:0] p;
      p = '0;
      for (int k = 0; k < 12; k++) p[k*16 +: 16] = 16'((n << 8) + k + 'h1000);
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tbl_wr(input logic [5:0] a, input logic [3:0] r, input logic [11:0] m);
      i_exwe = 1'b1;
      i_exa  = a;
      i_exwd = {r, m};
      step();
      i_exwe = 1'b0;
   endtask

   localparam logic [191:0] LANE_IDX =
      {16'd11, 16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
   localparam logic [191:0] ROT2 =
      {16'd1, 16'd0, 16'd11, 16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2};

   initial begin
      rst_n = 1'b0; i_op_valid = 1'b0; i_op_func = '0; i_op_addr = '0;
      i_delay = '0; i_cmp_mode = 1'b0; i_fpearray = '0;
      i_exwe = 1'b0; i_exre = 1'b0; i_exa = '0; i_exwd = '0;
      repeat (3) step();
      @(negedge clk);
      check_eq("rst_we",    192'(o_dmemwe),   192'(0));
      check_eq("rst_work",  192'(o_working),  192'(0));
      check_eq("rst_skip",  192'(o_skip_cnt), 192'(0));
      check_eq("rst_addr",  192'(o_addr),     192'(0));
      check_eq("rst_data",  o_todmem,         192'(0));
      check_eq("rst_exrd",  192'(o_exrd),     192'(0));
      step();
      rst_n = 1'b1;
      step();

      tbl_wr(6'd3, 4'd0, 12'hFFF);
      tbl_wr(6'd1, 4'd2, 12'h00F);
      tbl_wr(6'd2, 4'd14, 12'hFFF);

      // delay 5: op in cycle 0 writes in cycle 7 with data sampled in cycle 6
      i_delay = 4'd5;
      for (int n = 0; n < 10; n++) begin
         i_op_valid = (n == 0);
         i_op_func  = 6'd3;
         i_op_addr  = 16'h0040;
         i_fpearray = pat(n);
         @(negedge clk);
         check_eq("lat_we", 192'(o_dmemwe), (n == 7) ? 192'(12'hFFF) : 192'(0));
         if (n == 7) check_eq("lat_data", o_todmem, pat(6));
         if (n >= 7) check_eq("lat_addr", 192'(o_addr), 192'(16'h0040));
         step();
      end

      // rotate 2 and rotate 14 (wraps to 2) with delay 0
      i_delay    = 4'd0;
      i_fpearray = LANE_IDX;
      for (int t = 0; t < 2; t++) begin
         for (int n = 0; n < 4; n++) begin
            i_op_valid = (n == 0);
            i_op_func  = (t == 0) ? 6'd1 : 6'd2;
            i_op_addr  = 16'h0011;
            @(negedge clk);
            if (t == 0) begin
               check_eq("rot2_we", 192'(o_dmemwe), (n == 2) ? 192'(12'h00F) : 192'(0));
               if (n == 2) check_eq("rot2_lo", 192'(o_todmem[63:0]), 192'(64'h0005_0004_0003_0002));
            end else begin
               check_eq("rot14_we", 192'(o_dmemwe), (n == 2) ? 192'(12'hFFF) : 192'(0));
            end
            if (n == 2) check_eq("rot_data", o_todmem, ROT2);
            step();
         end
      end
      repeat (3) step();

      // four back-to-back ops at the maximum delay
      i_delay = 4'd15;
      for (int n = 0; n < 23; n++) begin
         i_op_valid = (n < 4);
         i_op_func  = 6'd3;
         i_op_addr  = 16'(16'h0100 + n);
         i_fpearray = pat(n + 32);
         @(negedge clk);
         check_eq("b2b_we",   192'(o_dmemwe),  (n >= 17 && n <= 20) ? 192'(12'hFFF) : 192'(0));
         check_eq("b2b_work", 192'(o_working), (n >= 1 && n <= 20) ? 192'(1) : 192'(0));
         if (n >= 17 && n <= 20) begin
            check_eq("b2b_addr", 192'(o_addr), 192'(16'h0100 + n - 17));
            check_eq("b2b_data", o_todmem, pat(n - 1 + 32));
         end
         step();
      end

      // suppression: three identical ops, then one with new data
      i_delay    = 4'd0;
      i_cmp_mode = 1'b1;
      for (int n = 0; n < 7; n++) begin
         i_op_valid = (n < 4);
         i_op_func  = 6'd3;
         i_op_addr  = 16'h0200;
         i_fpearray = (n < 4) ? pat(100) : pat(101);
         @(negedge clk);
         check_eq("cmp_we", 192'(o_dmemwe), (n == 2 || n == 5) ? 192'(12'hFFF) : 192'(0));
         if (n == 5) check_eq("cmp_data", o_todmem, pat(101));
         if (n >= 5) check_eq("cmp_cnt", 192'(o_skip_cnt), 192'(2));
         step();
      end
      i_cmp_mode = 1'b0;

      // unprogrammed func 9 issues no write
      for (int n = 0; n < 4; n++) begin
         i_op_valid = (n == 0);
         i_op_func  = 6'd9;
         i_op_addr  = 16'h0333;
         @(negedge clk);
         check_eq("unprog_we", 192'(o_dmemwe), 192'(0));
         if (n == 2) check_eq("unprog_addr", 192'(o_addr), 192'(16'h0333));
         step();
      end

      // table read, simultaneous write/read returns old value, then new value
      i_op_valid = 1'b0;
      i_exre = 1'b1; i_exa = 6'd3;
      step();
      i_exre = 1'b0;
      @(negedge clk);
      check_eq("exrd_3", 192'(o_exrd), 192'(16'h0FFF));
      step();
      i_exwe = 1'b1; i_exre = 1'b1; i_exa = 6'd5; i_exwd = 16'h3ABC;
      step();
      i_exwe = 1'b0; i_exre = 1'b0;
      @(negedge clk);
      check_eq("exrd_old", 192'(o_exrd), 192'(0));
      step();
      @(negedge clk);
      check_eq("exrd_hold", 192'(o_exrd), 192'(0));
      step();
      i_exre = 1'b1; i_exa = 6'd5;
      step();
      i_exre = 1'b0;
      @(negedge clk);
      check_eq("exrd_new", 192'(o_exrd), 192'(16'h3ABC));
      step();

      // reset with three ops in flight
      i_delay = 4'd5;
      for (int n = 0; n < 15; n++) begin
         i_op_valid = (n < 3);
         i_op_func  = 6'd3;
         i_op_addr  = 16'h0400;
         if (n == 3) rst_n = 1'b0;
         if (n == 4) rst_n = 1'b1;
         @(negedge clk);
         if (n >= 3) begin
            check_eq("rst_fl_we",   192'(o_dmemwe),   192'(0));
            check_eq("rst_fl_work", 192'(o_working),  192'(0));
            check_eq("rst_fl_skip", 192'(o_skip_cnt), 192'(0));
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
